// File: rtl/divider_if.sv
// Handshake bundle for the iterative divider.
// Handshake: a request transfers on a rising clk edge where start=1 and ready=1;
// a, b and d_signed are captured on that edge only. done is a one-cycle pulse
// marking q/r/div_by_zero valid; those outputs then hold until the next result.
// dbg_state mirrors the controller state for observation only.
interface divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             d_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, d_signed, a, b,
        input  ready, done, q, r, div_by_zero, dbg_state
    );

    modport slave (
        input  start, d_signed, a, b,
        output ready, done, q, r, div_by_zero, dbg_state
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Signed or unsigned operands; quotient truncates toward zero and the
// remainder takes the sign of the dividend.
// Optional feature macro: DIVIDER_BYPASS_EN -- a zero divisor skips the
// iteration and finishes two cycles after the request.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prep_q, prep_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic             ready;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign a_neg  = sgn_q & a_q[WIDTH-1];
    assign b_neg  = sgn_q & b_q[WIDTH-1];
    assign b_zero = (b_q == '0);

    // The partial remainder after the left shift needs one extra bit, since it
    // can reach 2*|b|-1 before the trial subtraction.
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign rem_ge = (rem_sh >= {1'b0, bmag_q});

    assign bus.ready       = ready;
    assign bus.done        = (state_q == S_DONE);
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dbg_state   = state_q;

    // State register and datapath flops; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath: capture, magnitude prep, shift/subtract, sign fix.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_BUSY;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sgn_d   = bus.d_signed;
                    cnt_d   = CW'(WIDTH - 1);
                    prep_d  = 1'b1;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_BUSY: begin
                if (prep_q) begin
                    // Magnitudes are formed from the captured operands here,
                    // keeping the negation off the request path.
                    prep_d = 1'b0;
                    dvd_d  = a_neg ? (-a_q) : a_q;
                    bmag_d = b_neg ? (-b_q) : b_q;
                    rem_d  = '0;
`ifdef DIVIDER_BYPASS_EN
                    if (b_zero) begin
                        state_d = S_FIX;
                    end
`endif
                end else begin
                    rem_d = rem_ge ? WIDTH'(rem_sh - {1'b0, bmag_q}) : rem_sh[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                state_d = S_DONE;
                if (b_zero) begin
                    q_d   = '1;
                    r_d   = a_q;
                    dbz_d = 1'b1;
                end else begin
                    q_d   = (a_neg ^ b_neg) ? (-dvd_q) : dvd_q;
                    r_d   = a_neg ? (-rem_q) : rem_q;
                    dbz_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed vectors, protocol and reset
// cases, then randomized operations against an arithmetic reference model.
module tb_divider;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [W-1:0] exp_q[$];

    divider_if #(.WIDTH(W)) bus ();

    divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division in wide signed arithmetic, divide by zero by rule.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output logic edz);
        longint sa;
        longint sb;
        if (b == '0) begin
            eq  = '1;
            er  = a;
            edz = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            eq  = W'(sa / sb);
            er  = W'(sa % sb);
            edz = 1'b0;
        end else begin
            eq  = a / b;
            er  = a % b;
            edz = 1'b0;
        end
    endfunction

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef DIVIDER_BYPASS_EN
        return (b == '0) ? 2 : W + 2;
`else
        return W + 2;
`endif
    endfunction

    // Driver: issues one request from a ready cycle and checks its result.
    // Returns in the done cycle so the caller may issue back-to-back.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic is, input logic hold);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           lat;
        int           rdy_seen;
        int           dones;
        model(ia, ib, is, eq, er, edz);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        check("ready_at_start", 64'(bus.ready), 64'(1));
        bus.start    = 1'b1;
        bus.a        = ia;
        bus.b        = ib;
        bus.d_signed = is;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.d_signed = 1'($urandom_range(0, 1));
        lat      = 0;
        rdy_seen = 0;
        dones    = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat   = k;
                dones = 1;
                break;
            end
            if (bus.ready) rdy_seen++;
        end
        bus.start = 1'b0;
        check("latency", 64'(lat), 64'(exp_latency(ib)));
        check("ready_low_busy", 64'(rdy_seen), 64'(0));
        check("done_seen", 64'(dones), 64'(1));
        check("q", 64'(bus.q), 64'(exp_q.pop_front()));
        check("r", 64'(bus.r), 64'(exp_q.pop_front()));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(edz));
    endtask

    // After a lone op: done must drop, unit idle, results held.
    task automatic idle_check(input logic [W-1:0] hq, input logic [W-1:0] hr);
        @(posedge clk);
        #1;
        check("done_single_pulse", 64'(bus.done), 64'(0));
        check("ready_idle", 64'(bus.ready), 64'(1));
        check("q_held", 64'(bus.q), 64'(hq));
        check("r_held", 64'(bus.r), 64'(hr));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           cnt_done;
        int           cnt_busy;

        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.d_signed = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.ready), 64'(1));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_q", 64'(bus.q), 64'(0));
        check("rst_r", 64'(bus.r), 64'(0));
        check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors.
        run_op(32'd325401, 32'd45621, 1'b0, 1'b0);
        idle_check(32'd7, 32'd6054);
        run_op(-32'sd492901, 32'd32973, 1'b1, 1'b0);
        run_op(-32'sd971436, -32'sd78525, 1'b1, 1'b0);
        idle_check(32'd12, -32'sd29136);
        run_op(32'd100, 32'd0, 1'b1, 1'b0);
        idle_check(32'hFFFF_FFFF, 32'd100);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'd0, 32'd17, 1'b1, 1'b0);
        run_op(-32'sd12345, 32'd1, 1'b1, 1'b0);
        run_op(32'd5, -32'sd9, 1'b1, 1'b0);
        idle_check(32'd0, 32'd5);

        // Start held high through the whole operation: exactly one result.
        run_op(32'd999999, 32'd1000, 1'b0, 1'b1);
        idle_check(32'd999, 32'd999);

        // Reset asserted during the 10th busy cycle aborts the operation.
        bus.a        = 32'd77777;
        bus.b        = 32'd3;
        bus.d_signed = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midrst_ready", 64'(bus.ready), 64'(1));
        check("midrst_done", 64'(bus.done), 64'(0));
        check("midrst_q", 64'(bus.q), 64'(0));
        check("midrst_r", 64'(bus.r), 64'(0));
        cnt_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt_done++;
        end
        check("midrst_no_done", 64'(cnt_done), 64'(0));

        // Reset and start on the same edge: start is dropped.
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 32'd40;
        bus.b     = 32'd6;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b0;
        cnt_done  = 0;
        cnt_busy  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt_done++;
            if (!bus.ready) cnt_busy++;
        end
        check("rststart_no_done", 64'(cnt_done), 64'(0));
        check("rststart_no_busy", 64'(cnt_busy), 64'(0));

        // Randomized operations, alternately back-to-back.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = -W'($urandom_range(1, 15));
                3:       rb = W'($urandom_range(1, 1 << 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, 1'b0);
            if (n % 2 == 1) begin
                model(ra, rb, rs, eq, er, edz);
                idle_check(eq, er);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
